// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } uart_rx_state_t;

    typedef struct packed {
        logic break_detect;
        logic frame_error;
        logic parity_error;
    } uart_rx_status_t;

    localparam int unsigned UART_STATUS_W = 3;

    // Out-of-range data-bit settings fall back to the widest frame.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] cfg, input int unsigned max_bits);
        if (cfg < 4'd5 || {28'd0, cfg} > max_bits) begin
            return 4'(max_bits);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy and drop/handshake strobes.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_next_o,
    output logic                         wr_o,
    output logic                         rd_o,
    output logic                         drop_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // Handshake: pop_i is accepted only when not empty; push_i is accepted when
    // not full or when a pop is accepted in the same cycle, otherwise it is dropped.
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign rd_o         = pop_i && !empty_o;
    assign wr_o         = push_i && (!full_o || rd_o);
    assign drop_o       = push_i && !wr_o;
    assign count_next_o = count_q + CW'(wr_o) - CW'(rd_o);
    assign count_o      = count_q;
    assign rdata_o      = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (wr_o) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_o) wr_ptr <= wr_ptr + AW'(1);
            if (rd_o) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_next_o;
        end
    end

endmodule

// File: rtl/uart_rx_channel.sv
// Oversampled majority-vote UART receiver with status FIFO, RTS watermark and idle timeout.
module uart_rx_channel
    import uart_pkg::*;
#(
    parameter int unsigned DATA_MAX   = 9,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RTS_LEVEL  = FIFO_DEPTH - 2,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic [DIV_WIDTH-1:0]              divider_i,
    input  logic [3:0]                        data_bits_i,
    input  logic                              parity_en_i,
    input  logic                              parity_odd_i,
    input  logic                              stop2_i,
    input  logic [7:0]                        timeout_i,
    input  logic                              rx_i,
    input  logic                              pop_i,
    output logic [DATA_MAX-1:0]               data_o,
    output uart_rx_status_t                   status_o,
    output logic                              empty_o,
    output logic                              full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              overrun_o,
    input  logic                              clr_overrun_i,
    output logic                              rts_o,
    output logic                              busy_o,
    output logic                              timeout_o,
    output uart_rx_state_t                    dbg_state_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned EW = DATA_MAX + UART_STATUS_W;
    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    uart_rx_state_t state_q, state_d;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic                 s_a, s_b, vote, vote_tick;
    logic [DATA_MAX-1:0]  data_sh;
    logic [3:0]           bit_cnt, nbits, shamt;
    logic                 stop_cnt, ferr_q, perr_q, all_zero_q;
    logic                 push, brk;
    logic [DATA_MAX-1:0]  push_data;
    uart_rx_status_t      push_status;

    logic [EW-1:0]        fifo_rdata;
    logic [CW-1:0]        fifo_count_next;
    logic                 fifo_wr, fifo_rd, fifo_drop;

    logic [SW-1:0]        tmo_samp;
    logic [7:0]           tmo_bits;
    logic                 tmo_armed, timeout_q, overrun_q, rts_q;

    assign tick = enable_i && (div_cnt >= divider_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // The start-detect tick counts as tick 0, so the counter is parked at 1 while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == ST_IDLE) begin
            samp_cnt <= SW'(1);
        end else if (tick) begin
            samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == S_A) s_a <= rx_i;
            if (samp_cnt == S_B) s_b <= rx_i;
        end
    end

    assign vote      = (s_a & s_b) | (s_a & rx_i) | (s_b & rx_i);
    assign vote_tick = tick && (samp_cnt == S_C);
    assign nbits     = eff_data_bits(data_bits_i, DATA_MAX);
    assign shamt     = 4'(DATA_MAX) - nbits;
    assign brk       = all_zero_q && !vote;

    assign push_data                = brk ? '0 : (data_sh >> shamt);
    assign push_status.break_detect = brk;
    assign push_status.frame_error  = ferr_q | !vote;
    assign push_status.parity_error = perr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (tick && !rx_i) state_d = ST_START;
                ST_START:      if (vote_tick) state_d = vote ? ST_IDLE : ST_DATA;
                ST_DATA:       if (vote_tick && bit_cnt == nbits - 4'd1)
                                   state_d = parity_en_i ? ST_PARITY : ST_STOP;
                ST_PARITY:     if (vote_tick) state_d = ST_STOP;
                ST_STOP: begin
                    if (vote_tick && (stop_cnt || !stop2_i)) begin
                        push    = 1'b1;
                        state_d = brk ? ST_BREAK_WAIT : ST_IDLE;
                    end
                end
                ST_BREAK_WAIT: if (tick && rx_i) state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Data shifts in at the MSB and is right-aligned by shamt when pushed.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == ST_IDLE) begin
            data_sh    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            all_zero_q <= 1'b1;
        end else if (vote_tick) begin
            if (vote && state_q != ST_START) all_zero_q <= 1'b0;
            case (state_q)
                ST_DATA: begin
                    data_sh <= {vote, data_sh[DATA_MAX-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                ST_PARITY: perr_q <= vote != ((^data_sh) ^ parity_odd_i);
                ST_STOP: begin
                    stop_cnt <= 1'b1;
                    if (!vote) ferr_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .wdata_i      ({push_status, push_data}),
        .pop_i        (pop_i),
        .rdata_o      (fifo_rdata),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .count_next_o (fifo_count_next),
        .wr_o         (fifo_wr),
        .rd_o         (fifo_rd),
        .drop_o       (fifo_drop)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            if (fifo_drop) overrun_q <= 1'b1;
            else if (clr_overrun_i) overrun_q <= 1'b0;
            rts_q <= (32'(fifo_count_next) < RTS_LEVEL);
        end
    end

    // Idle timeout counts whole bit times; one pulse per push/pop event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_samp  <= '0;
            tmo_bits  <= '0;
            tmo_armed <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (fifo_wr || fifo_rd) begin
                tmo_samp  <= '0;
                tmo_bits  <= '0;
                tmo_armed <= 1'b1;
            end else if (tick && state_q == ST_IDLE && !empty_o && tmo_armed && timeout_i != 8'd0) begin
                if (tmo_samp == S_LAST) begin
                    tmo_samp <= '0;
                    if (tmo_bits == timeout_i - 8'd1) begin
                        timeout_q <= 1'b1;
                        tmo_armed <= 1'b0;
                    end else begin
                        tmo_bits <= tmo_bits + 8'd1;
                    end
                end else begin
                    tmo_samp <= tmo_samp + SW'(1);
                end
            end
        end
    end

    assign data_o      = fifo_rdata[DATA_MAX-1:0];
    assign status_o    = uart_rx_status_t'(fifo_rdata[EW-1:DATA_MAX]);
    assign overrun_o   = overrun_q;
    assign rts_o       = rts_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule
